fwd_hazard_unit: RTL and testbench
==================================

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 The block SHALL have parameter AW, default 5, meaning register-address width.
REQ-002 The block SHALL have parameter NSRC, default 2, meaning operands per instruction.
REQ-003 The block SHALL have parameter NSTAGE, default 2, meaning forwarding stages; index 0 is youngest (EX/MEM).
REQ-004 The block SHALL have parameter LONG_LAT, default 4, meaning long-op latency in cycles, at least 2.
REQ-005 The block SHALL have derived constant SELW = clog2(NSTAGE+1).
REQ-006 The block SHALL have ports, listed as name  direction  width  meaning:
- clk  in  1  the single clock.
- rst  in  1  reset, asynchronous, active-high.
- ex_src_addr  in  NSRC*AW  EX-stage operand addresses.
- id_src_addr  in  NSRC*AW  ID-stage operand addresses.
- id_src_used  in  NSRC  ID operand actually read.
- stg_wr_en  in  NSTAGE  stage k will write the register file.
- stg_wr_addr  in  NSTAGE*AW  stage k destination.
- stg_data_rdy  in  NSTAGE  stage k result is forwardable.
- ex_is_load  in  1  EX instruction is a load.
- ex_wr_addr  in  AW  EX destination.
- id_long_issue  in  1  ID requests a long-latency op.
- id_wr_addr  in  AW  ID destination.
- flush  in  1  squash the ID instruction.
- fwd_sel  out  NSRC*SELW  0 = register file, k+1 = stage k.
- stall  out  1  hold PC and IF/ID, insert bubble.
- long_wb_valid  out  1  long-op writeback pulse.
- long_wb_addr  out  AW  long-op destination.
- long_busy  out  1  tracker not IDLE.
- stall_cnt  out  16  saturating stall-cycle count.

Function
REQ-007 Per operand i, fwd_sel SHALL select the lowest k with stg_wr_en[k], stg_data_rdy[k], stg_wr_addr[k]==ex_src_addr[i] and address nonzero, else 0; the selection is combinational.
REQ-008 A matching stage with stg_data_rdy==0 SHALL mask all older stages for that operand, so fwd_sel is 0.
REQ-009 Load-use: stall SHALL be 1 when ex_is_load, ex_wr_addr!=0, and some id_src_used[i] has id_src_addr[i]==ex_wr_addr.
REQ-010 The long-op tracker SHALL be an FSM with states IDLE, BUSY and DONE, holding registers dest[AW] and cnt.
REQ-011 In IDLE or DONE, a long op SHALL be accepted when id_long_issue, stall==0 and flush==0; on acceptance the next state is BUSY, cnt=LONG_LAT-2 and dest=id_wr_addr.
REQ-012 In BUSY, cnt SHALL decrement each cycle; at cnt==0 the next state is DONE.
REQ-013 In DONE, long_wb_valid SHALL be 1 and long_wb_addr SHALL equal dest for exactly one cycle; the next state is BUSY if an op is accepted, else IDLE.
REQ-014 The total time from the acceptance edge to long_wb_valid high SHALL be LONG_LAT cycles.
REQ-015 Long-op RAW hazard: stall SHALL be 1 in BUSY or DONE when dest!=0 and some used ID source equals dest.
REQ-016 Long-op WAW hazard: stall SHALL be 1 in BUSY or DONE when id_wr_addr==dest and the ID instruction writes (id_long_issue).
REQ-017 Structural hazard: stall SHALL be 1 when id_long_issue occurs in BUSY.
REQ-018 flush SHALL suppress acceptance and force stall to 0; it SHALL NOT abort an op already in BUSY or DONE.
REQ-019 Address 0 SHALL never create a hazard or a forward.
REQ-020 stall_cnt SHALL increment on each clock edge with stall==1 and SHALL saturate at 16'hFFFF.
REQ-021 long_busy SHALL be 1 when the state is not IDLE.

Reset
REQ-022 While rst==1, state SHALL be IDLE, cnt=0, dest=0, stall_cnt=0, long_wb_valid=0, long_wb_addr=0 and long_busy=0, asynchronously.
REQ-023 Reset during BUSY SHALL discard the op with no writeback pulse.
REQ-024 Combinational outputs SHALL follow their inputs during reset, except that the tracker terms are 0.

Structure
REQ-025 Package fwd_pkg SHALL hold the state enum (IDLE/BUSY/DONE) and the SELW function.
REQ-026 Sub-module fwd_src_select SHALL implement the per-operand priority select of REQ-007/008 and SHALL be instantiated NSRC times.

Verification
REQ-027 The bench SHALL cover this scenario: stg0 writes r5 with rdy=1 and stg1 writes r5; ex_src0=r5 -> fwd_sel[0]=1.
REQ-028 The bench SHALL cover this scenario: stg0 writes r5 with rdy=0 and stg1 writes r5 with rdy=1 -> fwd_sel[0]=0; ex_src=r0 with all stages writing r0 -> 0.
REQ-029 The bench SHALL cover this scenario: ex_is_load, ex_wr_addr=r3, id_src1=r3 used -> stall=1 for 1 cycle and stall_cnt=1.
REQ-030 The bench SHALL cover this scenario: long issue to r7 at cycle 0 with LONG_LAT=4 -> long_wb_valid at cycle 4 with addr=7; ID read of r7 at cycles 1..4 -> stall=1.
REQ-031 The bench SHALL cover this scenario: second issue in BUSY -> stall; issue in DONE -> back-to-back BUSY and a second pulse 4 cycles later.
REQ-032 The bench SHALL cover this scenario: rst asserted mid-BUSY -> IDLE immediately, no pulse; flush with issue -> no acceptance.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding / hazard unit.
// Holds the long-op tracker state encoding and the forward-select width function.
package fwd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } long_state_e;

  // Select code 0 means register file, k+1 means stage k.
  function automatic int selw(input int nstage);
    return $clog2(nstage + 1);
  endfunction

endpackage

// File: rtl/fwd_src_select.sv
// Per-operand forwarding priority select.
// The youngest matching stage wins; a matching stage without ready data blocks older stages.
module fwd_src_select #(
  parameter int AW     = 5,
  parameter int NSTAGE = 2,
  parameter int SELW   = 2
) (
  input  logic [AW-1:0]        src_addr,
  input  logic [NSTAGE-1:0]    stg_wr_en,
  input  logic [NSTAGE*AW-1:0] stg_wr_addr,
  input  logic [NSTAGE-1:0]    stg_data_rdy,
  output logic [SELW-1:0]      sel
);

  // Walk oldest to youngest so the youngest match overrides.
  always_comb begin
    sel = '0;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      if (stg_wr_en[k] && (src_addr != '0) && (stg_wr_addr[k*AW +: AW] == src_addr)) begin
        sel = stg_data_rdy[k] ? SELW'(k + 1) : '0;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding, load-use and long-latency hazard detection for an in-order pipeline.
// Also tracks one outstanding long-latency op and counts stall cycles.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int AW       = 5,
  parameter int NSRC     = 2,
  parameter int NSTAGE   = 2,
  parameter int LONG_LAT = 4,
  localparam int SELW    = selw(NSTAGE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NSRC*AW-1:0]   ex_src_addr,
  input  logic [NSRC*AW-1:0]   id_src_addr,
  input  logic [NSRC-1:0]      id_src_used,
  input  logic [NSTAGE-1:0]    stg_wr_en,
  input  logic [NSTAGE*AW-1:0] stg_wr_addr,
  input  logic [NSTAGE-1:0]    stg_data_rdy,
  input  logic                 ex_is_load,
  input  logic [AW-1:0]        ex_wr_addr,
  input  logic                 id_long_issue,
  input  logic [AW-1:0]        id_wr_addr,
  input  logic                 flush,
  output logic [NSRC*SELW-1:0] fwd_sel,
  output logic                 stall,
  output logic                 long_wb_valid,
  output logic [AW-1:0]        long_wb_addr,
  output logic                 long_busy,
  output logic [15:0]          stall_cnt
);

  localparam int CW = (LONG_LAT > 2) ? $clog2(LONG_LAT - 1) : 1;

  long_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] dest_q, dest_d;
  logic [15:0]   stall_cnt_q;

  logic load_use, long_raw, long_waw, long_struct, tracking, accept;

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    fwd_src_select #(.AW(AW), .NSTAGE(NSTAGE), .SELW(SELW)) u_sel (
      .src_addr     (ex_src_addr[gi*AW +: AW]),
      .stg_wr_en    (stg_wr_en),
      .stg_wr_addr  (stg_wr_addr),
      .stg_data_rdy (stg_data_rdy),
      .sel          (fwd_sel[gi*SELW +: SELW])
    );
  end

  // Tracker terms vanish in reset because the state register is already IDLE.
  always_comb begin
    tracking    = (state_q == BUSY) || (state_q == DONE);
    load_use    = 1'b0;
    long_raw    = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (id_src_used[i] && ex_is_load && (ex_wr_addr != '0) &&
          (id_src_addr[i*AW +: AW] == ex_wr_addr))
        load_use = 1'b1;
      if (id_src_used[i] && tracking && (dest_q != '0) &&
          (id_src_addr[i*AW +: AW] == dest_q))
        long_raw = 1'b1;
    end
    long_waw    = tracking && id_long_issue && (dest_q != '0) && (id_wr_addr == dest_q);
    long_struct = (state_q == BUSY) && id_long_issue;
    stall       = !flush && (load_use || long_raw || long_waw || long_struct);
    accept      = (state_q != BUSY) && id_long_issue && !stall && !flush;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dest_d  = dest_q;
    unique case (state_q)
      BUSY: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        if (accept) begin
          state_d = BUSY;
          cnt_d   = CW'(LONG_LAT - 2);
          dest_d  = id_wr_addr;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dest_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dest_q  <= dest_d;
      if (stall && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign long_wb_valid = (state_q == DONE);
  assign long_wb_addr  = long_wb_valid ? dest_q : '0;
  assign long_busy     = (state_q != IDLE);
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios plus randomized traffic
// compared against a cycle-timestamp reference model of forwarding and hazard rules.
module tb_fwd_hazard_unit;

  localparam int AW = 5, NSRC = 2, NSTAGE = 2, LONG_LAT = 4, SELW = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NSRC*AW-1:0]   ex_src_addr, id_src_addr;
  logic [NSRC-1:0]      id_src_used;
  logic [NSTAGE-1:0]    stg_wr_en, stg_data_rdy;
  logic [NSTAGE*AW-1:0] stg_wr_addr;
  logic                 ex_is_load, id_long_issue, flush;
  logic [AW-1:0]        ex_wr_addr, id_wr_addr;
  logic [NSRC*SELW-1:0] fwd_sel;
  logic                 stall, long_wb_valid, long_busy;
  logic [AW-1:0]        long_wb_addr;
  logic [15:0]          stall_cnt;

  fwd_hazard_unit #(.AW(AW), .NSRC(NSRC), .NSTAGE(NSTAGE), .LONG_LAT(LONG_LAT)) dut (
    .clk(clk), .rst(rst),
    .ex_src_addr(ex_src_addr), .id_src_addr(id_src_addr), .id_src_used(id_src_used),
    .stg_wr_en(stg_wr_en), .stg_wr_addr(stg_wr_addr), .stg_data_rdy(stg_data_rdy),
    .ex_is_load(ex_is_load), .ex_wr_addr(ex_wr_addr),
    .id_long_issue(id_long_issue), .id_wr_addr(id_wr_addr), .flush(flush),
    .fwd_sel(fwd_sel), .stall(stall), .long_wb_valid(long_wb_valid),
    .long_wb_addr(long_wb_addr), .long_busy(long_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  // Reference model: an outstanding op is remembered by the cycle its writeback is due.
  int          cyc = 0;
  bit          m_active = 0;
  int          m_wb_cyc = 0;
  int          m_dest = 0;
  int          m_scnt = 0;
  bit          m_in_done, e_stall, e_accept;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int a_of(input logic [NSRC*AW-1:0] v, input int i);
    return int'(v[i*AW +: AW]);
  endfunction

  function automatic int exp_fwd(input int i);
    int src = a_of(ex_src_addr, i);
    if (src == 0) return 0;
    for (int k = 0; k < NSTAGE; k++)
      if (stg_wr_en[k] && int'(stg_wr_addr[k*AW +: AW]) == src)
        return stg_data_rdy[k] ? k + 1 : 0;
    return 0;
  endfunction

  function automatic bit id_reads(input int addr);
    for (int i = 0; i < NSRC; i++)
      if (id_src_used[i] && a_of(id_src_addr, i) == addr) return 1;
    return 0;
  endfunction

  task automatic model_check();
    bit in_busy, track, lu, raw, waw, strc;
    if (rst) begin m_active = 0; m_scnt = 0; m_dest = 0; end
    m_in_done = m_active && (cyc == m_wb_cyc);
    in_busy   = m_active && (cyc < m_wb_cyc);
    track     = in_busy || m_in_done;
    lu   = ex_is_load && ex_wr_addr != 0 && id_reads(int'(ex_wr_addr));
    raw  = track && m_dest != 0 && id_reads(m_dest);
    waw  = track && id_long_issue && m_dest != 0 && int'(id_wr_addr) == m_dest;
    strc = in_busy && id_long_issue;
    e_stall  = !flush && (lu || raw || waw || strc);
    e_accept = !rst && !in_busy && id_long_issue && !e_stall && !flush;
    for (int i = 0; i < NSRC; i++)
      check_eq($sformatf("fwd_sel[%0d]", i), 32'(fwd_sel[i*SELW +: SELW]), 32'(exp_fwd(i)));
    check_eq("stall", 32'(stall), 32'(e_stall));
    check_eq("long_wb_valid", 32'(long_wb_valid), 32'(m_in_done));
    check_eq("long_wb_addr", 32'(long_wb_addr), m_in_done ? 32'(m_dest) : 32'd0);
    check_eq("long_busy", 32'(long_busy), 32'(track));
    check_eq("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
  endtask

  task automatic tick();
    if (!rst) begin
      if (e_accept) begin
        m_active = 1; m_wb_cyc = cyc + LONG_LAT; m_dest = int'(id_wr_addr);
      end else if (m_in_done) begin
        m_active = 0;
      end
      if (e_stall && m_scnt < 16'hFFFF) m_scnt++;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ex_src_addr = '0; id_src_addr = '0; id_src_used = '0;
    stg_wr_en = '0; stg_wr_addr = '0; stg_data_rdy = '0;
    ex_is_load = 0; ex_wr_addr = '0; id_long_issue = 0; id_wr_addr = '0; flush = 0;
  endtask

  // One checked cycle with the currently driven inputs.
  task automatic step();
    #3;
    model_check();
    tick();
  endtask

  task automatic issue(input int dst);
    clear_inputs(); id_long_issue = 1; id_wr_addr = AW'(dst);
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    #12;
    check_eq("reset_busy", 32'(long_busy), 0);
    check_eq("reset_cnt", 32'(stall_cnt), 0);
    @(posedge clk); #1;
    rst = 0;

    // Youngest ready stage wins.
    stg_wr_en = 2'b11; stg_data_rdy = 2'b11; stg_wr_addr = {5'd5, 5'd5};
    ex_src_addr = {5'd0, 5'd5};
    #3; check_eq("fwd_young", 32'(fwd_sel[SELW-1:0]), 1); step();
    // Youngest match not ready masks the older ready one.
    stg_data_rdy = 2'b10;
    #3; check_eq("fwd_mask", 32'(fwd_sel[SELW-1:0]), 0); step();
    stg_data_rdy = 2'b10; stg_wr_en = 2'b10;
    #3; check_eq("fwd_old", 32'(fwd_sel[SELW-1:0]), 2); step();
    stg_wr_en = 2'b11; stg_data_rdy = 2'b11; stg_wr_addr = '0; ex_src_addr = '0;
    #3; check_eq("fwd_r0", 32'(fwd_sel), 0); step();

    // Load-use on operand 1.
    clear_inputs();
    ex_is_load = 1; ex_wr_addr = 5'd3; id_src_addr = {5'd3, 5'd0}; id_src_used = 2'b10;
    #3; check_eq("lu_stall", 32'(stall), 1); step();
    clear_inputs();
    #3; check_eq("lu_release", 32'(stall), 0); check_eq("lu_cnt", 32'(stall_cnt), 1); step();

    // Long op to r7, dependent read during cycles 1..4.
    issue(7); step();
    for (int c = 1; c <= 4; c++) begin
      clear_inputs(); id_src_addr = {5'd0, 5'd7}; id_src_used = 2'b01;
      #3; check_eq("raw_stall", 32'(stall), 1);
      if (c == 4) check_eq("wb_addr7", 32'(long_wb_addr), 7);
      step();
    end
    clear_inputs(); #3; check_eq("idle_after", 32'(long_busy), 0); step();

    // Structural stall in BUSY, back-to-back issue from DONE.
    issue(7); step();
    issue(9); #3; check_eq("struct_stall", 32'(stall), 1); step();
    clear_inputs(); step(); step();
    issue(9); #3; check_eq("done_pulse", 32'(long_wb_valid), 1); step();
    clear_inputs();
    for (int c = 0; c < 3; c++) step();
    #3; check_eq("second_pulse", 32'(long_wb_addr), 9); step();

    // Reset mid-BUSY drops the op; flush blocks acceptance.
    issue(11); step();
    clear_inputs(); step();
    rst = 1; #1;
    check_eq("rst_async", 32'(long_busy), 0);
    step();
    rst = 0;
    for (int c = 0; c < 5; c++) step();
    issue(12); flush = 1; #3; check_eq("flush_stall", 32'(stall), 0); step();
    clear_inputs(); #3; check_eq("flush_noacc", 32'(long_busy), 0); step();

    // Randomized traffic with small address range for frequent matches.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NSRC; i++) begin
        ex_src_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
        id_src_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
      end
      for (int k = 0; k < NSTAGE; k++) stg_wr_addr[k*AW +: AW] = AW'($urandom_range(0, 7));
      id_src_used   = NSRC'($urandom);
      stg_wr_en     = NSTAGE'($urandom);
      stg_data_rdy  = NSTAGE'($urandom);
      ex_is_load    = ($urandom_range(0, 3) == 0);
      ex_wr_addr    = AW'($urandom_range(0, 7));
      id_long_issue = ($urandom_range(0, 2) == 0);
      id_wr_addr    = AW'($urandom_range(0, 7));
      flush         = ($urandom_range(0, 7) == 0);
      rst           = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 0; clear_inputs(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
